// File: rtl/prefix_sum_out_stage_if.sv
//----------------------------------------------------------------------------
// Module   : prefix_sum_out_stage_if
// Brief    : Input/output handshake bundle for the prefix-adder output stage.
//            SUM_PARITY_EN adds the parity field.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface prefix_sum_out_stage_if #(
  parameter int WIDTH = 22
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:1]   hs;
  logic [WIDTH:1]   P;
  logic [WIDTH:1]   G;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:1]   sum;
  logic             cout;
  logic             ovf;
  logic             zero;
`ifdef SUM_PARITY_EN
  logic             parity;
`endif

  // Upstream prefix network and downstream consumer side.
  modport master (
    output in_valid, hs, P, G, cin, out_ready,
`ifdef SUM_PARITY_EN
    input  parity,
`endif
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // Output stage side.
  modport slave (
    input  in_valid, hs, P, G, cin, out_ready,
`ifdef SUM_PARITY_EN
    output parity,
`endif
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/prefix_sum_out_stage.sv
//----------------------------------------------------------------------------
// Module   : prefix_sum_out_stage
// Brief    : Folds carry-in into prefix P/G, forms sum/cout/ovf/zero and
//            registers them behind a 2-entry skid buffer. SUM_PARITY_EN
//            adds a registered even-parity output.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module prefix_sum_out_stage #(
  parameter int WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prefix_sum_out_stage_if.slave  bus
);

`ifdef SUM_PARITY_EN
  localparam int c_RW = WIDTH + 4;
`else
  localparam int c_RW = WIDTH + 3;
`endif

  // State encoding mirrors {M.valid, S.valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [c_RW-1:0]   r_m_data;
  logic [c_RW-1:0]   r_s_data;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_out_valid;
  logic              w_load_m_in;
  logic              w_load_m_skid;
  logic              w_load_s;

  logic [WIDTH:1]    w_c;
  logic [WIDTH:1]    w_sum;
  logic              w_cout;
  logic              w_ovf;
  logic              w_zero;
  logic [c_RW-1:0]   w_res;

  assign w_c[1] = bus.cin;

  generate
    for (genvar gi = 2; gi <= WIDTH; gi++) begin : g_carry
      assign w_c[gi] = bus.G[gi-1] | (bus.P[gi-1] & bus.cin);
    end
  endgenerate

  assign w_cout = bus.G[WIDTH] | (bus.P[WIDTH] & bus.cin);
  assign w_sum  = bus.hs ^ w_c;
  assign w_ovf  = w_c[WIDTH] ^ w_cout;
  assign w_zero = ~|w_sum;

  // Result word layout: {[parity,] zero, ovf, cout, sum}.
`ifdef SUM_PARITY_EN
  assign w_res = {^w_sum, w_zero, w_ovf, w_cout, w_sum};
`else
  assign w_res = {w_zero, w_ovf, w_cout, w_sum};
`endif

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_load_m_in = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_m_in = 1'b1;
        end else if (w_in_fire) begin
          w_load_s    = 1'b1;
          w_state_nxt = S_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the drain can happen.
        if (w_out_fire) begin
          w_load_m_skid = 1'b1;
          w_state_nxt   = S_ONE;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data <= '0;
      r_s_data <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_data <= w_res;
      end else if (w_load_m_skid) begin
        r_m_data <= r_s_data;
      end
      if (w_load_s) begin
        r_s_data <= w_res;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_m_data[WIDTH-1:0];
  assign bus.cout      = r_m_data[WIDTH];
  assign bus.ovf       = r_m_data[WIDTH+1];
  assign bus.zero      = r_m_data[WIDTH+2];
`ifdef SUM_PARITY_EN
  assign bus.parity    = r_m_data[WIDTH+3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_prefix_sum_out_stage.sv
//----------------------------------------------------------------------------
// Module   : tb_prefix_sum_out_stage
// Brief    : Scoreboard bench for prefix_sum_out_stage (SUM_PARITY_EN aware).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_prefix_sum_out_stage;
  localparam int W = 22;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prefix_sum_out_stage_if #(.WIDTH(W)) bus ();

  prefix_sum_out_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         par;
  } exp_t;

  exp_t exp_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   n_in      = 0;
  int   n_out     = 0;
  int   ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer addition with the sign rule for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero = (e.sum == '0);
    e.par  = ^e.sum;
    return e;
  endfunction

  // Group P/G over bits 1..i, as the upstream prefix network presents them.
  task automatic drive_operands(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:1] g_r;
    logic [W:1] p_r;
    logic       gb;
    logic       pb;
    for (int i = 1; i <= W; i++) begin
      gb = a[i-1] & b[i-1];
      pb = a[i-1] ^ b[i-1];
      if (i == 1) begin
        g_r[1] = gb;
        p_r[1] = pb;
      end else begin
        g_r[i] = gb | (pb & g_r[i-1]);
        p_r[i] = pb & p_r[i-1];
      end
    end
    bus.hs  = a ^ b;
    bus.P   = p_r;
    bus.G   = g_r;
    bus.cin = ci;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int t;
    t = 0;
    drive_operands(a, b, ci);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 required 1");
    end else begin
      exp_q.push_back(model(a, b, ci));
      n_in++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    ready_pct = 100;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : ready_driver
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  initial begin : monitor
    exp_t         e;
    logic [W+2:0] held;
    logic         stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(bus.out_valid), 64'(1));
          check("hold_fields", 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: sum=0x%0h with empty scoreboard", bus.sum);
          end else begin
            e = exp_q.pop_front();
            n_out++;
            check("sb_sum",  64'(bus.sum),  64'(e.sum));
            check("sb_cout", 64'(bus.cout), 64'(e.cout));
            check("sb_ovf",  64'(bus.ovf),  64'(e.ovf));
            check("sb_zero", 64'(bus.zero), 64'(e.zero));
`ifdef SUM_PARITY_EN
            check("sb_parity", 64'(bus.parity), 64'(e.par));
`endif
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        held    = {bus.sum, bus.cout, bus.ovf, bus.zero};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   t;
    exp_t e;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.hs       = '0;
    bus.P        = '0;
    bus.G        = '0;
    bus.cin      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_sum",       64'(bus.sum),       64'(0));
    check("rst_cout",      64'(bus.cout),      64'(0));
    check("rst_ovf",       64'(bus.ovf),       64'(0));
    check("rst_zero",      64'(bus.zero),      64'(0));
`ifdef SUM_PARITY_EN
    check("rst_parity",    64'(bus.parity),    64'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed vectors, one-cycle latency from acceptance.
    send(22'h3FFFFF, 22'h000001, 1'b0);
    @(negedge clk);
    check("v1_valid", 64'(bus.out_valid), 64'(1));
    check("v1_sum",   64'(bus.sum),       64'(22'h000000));
    check("v1_cout",  64'(bus.cout),      64'(1));
    check("v1_ovf",   64'(bus.ovf),       64'(0));
    check("v1_zero",  64'(bus.zero),      64'(1));
    @(posedge clk);
    #1;
    send(22'h1FFFFF, 22'h000001, 1'b0);
    @(negedge clk);
    check("v2_sum",   64'(bus.sum),  64'(22'h200000));
    check("v2_cout",  64'(bus.cout), 64'(0));
    check("v2_ovf",   64'(bus.ovf),  64'(1));
    check("v2_zero",  64'(bus.zero), 64'(0));
`ifdef SUM_PARITY_EN
    check("v2_parity", 64'(bus.parity), 64'(1));
`endif
    @(posedge clk);
    #1;
    send(22'h000000, 22'h000000, 1'b1);
    @(negedge clk);
    check("v3_sum",   64'(bus.sum),  64'(22'h000001));
    check("v3_cout",  64'(bus.cout), 64'(0));
    check("v3_ovf",   64'(bus.ovf),  64'(0));
    check("v3_zero",  64'(bus.zero), 64'(0));

    // Backpressure: fill M and S, third word waits.
    ready_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    send(22'd1, 22'd1, 1'b0);
    send(22'd2, 22'd2, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", 64'(bus.in_ready),  64'(0));
    check("bp_valid",        64'(bus.out_valid), 64'(1));
    check("bp_sum",          64'(bus.sum),       64'(22'd2));
    fork
      send(22'd3, 22'd3, 1'b0);
    join_none
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_sum",      64'(bus.sum),      64'(22'd2));
      check("bp_hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    ready_pct = 100;
    t = 0;
    @(negedge clk);
    while (!bus.out_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("bp_out0", 64'(bus.sum), 64'(22'd2));
    @(negedge clk);
    check("bp_out1", 64'(bus.sum), 64'(22'd4));
    @(negedge clk);
    check("bp_out2",      64'(bus.sum),       64'(22'd6));
    check("bp_in_ready",  64'(bus.in_ready),  64'(1));
    repeat (3) @(posedge clk);
    #1;

    // Random stream under random backpressure.
    ready_pct = 50;
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    check("stream_count", 64'(n_out), 64'(n_in));

    // Reset while FULL.
    ready_pct = 0;
    repeat (3) @(posedge clk);
    #1;
    send(22'h00000A, 22'h000005, 1'b0);
    send(22'h000010, 22'h000020, 1'b1);
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("mid_rst_sum",       64'(bus.sum),       64'(0));
    check("mid_rst_cout",      64'(bus.cout),      64'(0));
    check("mid_rst_ovf",       64'(bus.ovf),       64'(0));
    check("mid_rst_zero",      64'(bus.zero),      64'(0));
`ifdef SUM_PARITY_EN
    check("mid_rst_parity",    64'(bus.parity),    64'(0));
`endif
    exp_q.delete();
    n_in  = n_out;
    ready_pct = 100;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(22'h123456, 22'h0ABCDE, 1'b1);
    e = model(22'h123456, 22'h0ABCDE, 1'b1);
    @(negedge clk);
    check("post_rst_valid", 64'(bus.out_valid), 64'(1));
    check("post_rst_sum",   64'(bus.sum),       64'(e.sum));
    drain();
    check("final_count", 64'(n_out), 64'(n_in));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
